// File: rtl/kerneltop_kernel_b_vec_if.sv
// rtl/kerneltop_kernel_b_vec_if.sv - vector stream handshake bundle for kerneltop_kernel_b_vec
interface kerneltop_kernel_b_vec_if #(
  parameter int STREAMW = 32,
  parameter int NLANES  = 4
);
  logic                        ivalid;
  logic                        iready;
  logic [NLANES*STREAMW-1:0]   kb_vin;
  logic                        ovalid;
  logic                        oready;
  logic [NLANES*STREAMW-1:0]   kb_vout;
  logic                        olast;

  // Upstream/downstream driver side (testbench or surrounding fabric)
  modport master (
    output ivalid, kb_vin, oready,
    input  iready, ovalid, kb_vout, olast
  );

  // Kernel side
  modport slave (
    input  ivalid, kb_vin, oready,
    output iready, ovalid, kb_vout, olast
  );
endinterface

// File: rtl/kerneltop_kernel_b_vec.sv
// rtl/kerneltop_kernel_b_vec.sv - lane-parallel double/square pipeline with work-group last flag
module kerneltop_kernel_b_vec #(
  parameter int STREAMW    = 32,
  parameter int NLANES     = 4,
  parameter int PIPE_DEPTH = 2,
  parameter int OPMODE     = 0,
  parameter int NITEMS     = 1024
) (
  input logic clk,
  input logic rst,
  kerneltop_kernel_b_vec_if.slave bus
);
  localparam int W  = NLANES * STREAMW;
  localparam int CW = (NITEMS > 1) ? $clog2(NITEMS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NITEMS - 1);

  logic [W-1:0]          d [PIPE_DEPTH];
  logic [PIPE_DEPTH-1:0] v;
  logic [W-1:0]          f;
  logic [CW-1:0]         cnt;
  logic                  en;
  logic                  hs;

  // The whole pipe moves together; a full output stage only blocks when downstream stalls
  assign en = ~v[PIPE_DEPTH-1] | bus.oready;
  assign hs = v[PIPE_DEPTH-1] & bus.oready;

  // Per-lane arithmetic folded into the stage-0 load so no extra latency is added
  always_comb begin
    f = '0;
    for (int i = 0; i < NLANES; i++) begin
      if (OPMODE == 1)
        f[i*STREAMW +: STREAMW] = bus.kb_vin[i*STREAMW +: STREAMW] * bus.kb_vin[i*STREAMW +: STREAMW];
      else
        f[i*STREAMW +: STREAMW] = bus.kb_vin[i*STREAMW +: STREAMW] + bus.kb_vin[i*STREAMW +: STREAMW];
    end
  end

  // Shift register of data/valid pairs advanced by the global enable
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      for (int s = 0; s < PIPE_DEPTH; s++) d[s] <= '0;
    end else if (en) begin
      v[0] <= bus.ivalid;
      d[0] <= f;
      for (int s = 1; s < PIPE_DEPTH; s++) begin
        v[s] <= v[s-1];
        d[s] <= d[s-1];
      end
    end
  end

  // Output beat counter marking the final beat of each work-group
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (hs)
      cnt <= (cnt == LAST_CNT) ? '0 : cnt + CW'(1);
  end

  assign bus.iready  = en;
  assign bus.ovalid  = v[PIPE_DEPTH-1];
  assign bus.kb_vout = d[PIPE_DEPTH-1];
  assign bus.olast   = v[PIPE_DEPTH-1] & (cnt == LAST_CNT);
endmodule

// File: tb/tb_kerneltop_kernel_b_vec.sv
// tb/tb_kerneltop_kernel_b_vec.sv - scoreboard bench for doubling (NITEMS=4) and squaring (NITEMS=1) instances
module tb_kerneltop_kernel_b_vec;
  localparam int W = 128;

  logic clk = 0;
  logic rst;
  always #5 clk = ~clk;

  kerneltop_kernel_b_vec_if #(.STREAMW(32), .NLANES(4)) ia ();
  kerneltop_kernel_b_vec_if #(.STREAMW(32), .NLANES(4)) ib ();
  assign ib.ivalid = ia.ivalid;
  assign ib.kb_vin = ia.kb_vin;
  assign ib.oready = ia.oready;

  kerneltop_kernel_b_vec #(.STREAMW(32), .NLANES(4), .PIPE_DEPTH(2), .OPMODE(0), .NITEMS(4))
    dut_a (.clk(clk), .rst(rst), .bus(ia));
  kerneltop_kernel_b_vec #(.STREAMW(32), .NLANES(4), .PIPE_DEPTH(2), .OPMODE(1), .NITEMS(1))
    dut_b (.clk(clk), .rst(rst), .bus(ib));

  int errs = 0;
  int checks = 0;
  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  int cnt_a = 0;
  int lasts_a = 0;
  bit stall_a = 0, stall_b = 0;
  logic [W-1:0] prev_a, prev_b;
  logic prev_last_a, prev_last_b;

  function automatic logic [W-1:0] model(input logic [W-1:0] x, input bit sq);
    logic [W-1:0] r;
    logic [31:0] a;
    logic [63:0] p;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      a = x[i*32 +: 32];
      p = {32'd0, a} * {32'd0, a};
      r[i*32 +: 32] = sq ? p[31:0] : 32'(a + a);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Scoreboard for the doubling instance
  always @(negedge clk) begin
    if (!rst) begin
      if (stall_a) begin
        checks++;
        assert (ia.kb_vout === prev_a && ia.olast === prev_last_a) else begin
          errs++; $error("FAIL a_stable observed=%h/%b expected=%h/%b", ia.kb_vout, ia.olast, prev_a, prev_last_a);
        end
      end
      if (ia.ovalid && ia.oready) begin
        checks++;
        assert (qa.size() != 0) else begin
          errs++; $error("FAIL a_extra observed=%h expected=no beat", ia.kb_vout);
        end
        if (qa.size() != 0) begin
          logic [W-1:0] e;
          logic el;
          e = qa.pop_front();
          el = (cnt_a == 3);
          checks++;
          assert (ia.kb_vout === e) else begin
            errs++; $error("FAIL a_data observed=%h expected=%h", ia.kb_vout, e);
          end
          checks++;
          assert (ia.olast === el) else begin
            errs++; $error("FAIL a_olast observed=%b expected=%b", ia.olast, el);
          end
          cnt_a = el ? 0 : cnt_a + 1;
          if (ia.olast) lasts_a++;
        end
      end
      if (ia.ivalid && ia.iready) qa.push_back(model(ia.kb_vin, 0));
      stall_a = ia.ovalid && !ia.oready;
      prev_a = ia.kb_vout;
      prev_last_a = ia.olast;
    end
  end

  // Scoreboard for the squaring instance
  always @(negedge clk) begin
    if (!rst) begin
      if (stall_b) begin
        checks++;
        assert (ib.kb_vout === prev_b && ib.olast === prev_last_b) else begin
          errs++; $error("FAIL b_stable observed=%h/%b expected=%h/%b", ib.kb_vout, ib.olast, prev_b, prev_last_b);
        end
      end
      if (ib.ovalid && ib.oready) begin
        checks++;
        assert (qb.size() != 0) else begin
          errs++; $error("FAIL b_extra observed=%h expected=no beat", ib.kb_vout);
        end
        if (qb.size() != 0) begin
          logic [W-1:0] e;
          e = qb.pop_front();
          checks++;
          assert (ib.kb_vout === e && ib.olast === 1'b1) else begin
            errs++; $error("FAIL b_data observed=%h/%b expected=%h/1", ib.kb_vout, ib.olast, e);
          end
        end
      end
      if (ib.ivalid && ib.iready) qb.push_back(model(ib.kb_vin, 1));
      stall_b = ib.ovalid && !ib.oready;
      prev_b = ib.kb_vout;
      prev_last_b = ib.olast;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; ia.ivalid = 0; ia.oready = 1;
    @(posedge clk); #1;
    rst = 0;
    qa.delete(); qb.delete();
    cnt_a = 0; lasts_a = 0; stall_a = 0; stall_b = 0;
  endtask

  task automatic check_idle(input string tag);
    checks++;
    assert (ia.ovalid === 0 && ia.olast === 0 && ia.iready === 1 && ib.ovalid === 0 && ib.iready === 1)
    else begin
      errs++; $error("FAIL %s observed=ov%b ol%b ir%b/ov%b ir%b expected=ov0 ol0 ir1", tag,
                     ia.ovalid, ia.olast, ia.iready, ib.ovalid, ib.iready);
    end
  endtask

  // mode 0: oready high, 1: stall on cycles 4-6, 2: random oready
  task automatic stream(input int n, input int mode);
    int sent = 0;
    int k = 0;
    logic [W-1:0] cur = rnd();
    while (sent < n && k < 200) begin
      @(posedge clk); #1;
      ia.ivalid = 1;
      ia.kb_vin = cur;
      ia.oready = (mode == 1) ? !(k >= 4 && k <= 6) : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (mode == 1 && k >= 4 && k <= 6) begin
        checks++;
        assert (ia.iready === 1'b0) else begin
          errs++; $error("FAIL stall_iready observed=%b expected=0", ia.iready);
        end
      end
      if (ia.ivalid && ia.iready) begin sent++; cur = rnd(); end
      k++;
    end
    @(posedge clk); #1;
    ia.ivalid = 0; ia.oready = 1;
    checks++;
    assert (sent == n) else begin
      errs++; $error("FAIL stream_timeout observed=%0d expected=%0d", sent, n);
    end
  endtask

  task automatic drain(input string tag);
    int k = 0;
    ia.oready = 1;
    while ((qa.size() != 0 || qb.size() != 0) && k < 50) begin
      @(posedge clk); k++;
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    assert (qa.size() == 0 && qb.size() == 0) else begin
      errs++; $error("FAIL %s observed=%0d/%0d pending expected=0/0", tag, qa.size(), qb.size());
    end
  endtask

  initial begin
    rst = 1; ia.ivalid = 0; ia.kb_vin = '0; ia.oready = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check_idle("reset_idle");
    checks++;
    assert (ia.kb_vout === '0 && ib.kb_vout === '0) else begin
      errs++; $error("FAIL reset_vout observed=%h/%h expected=0", ia.kb_vout, ib.kb_vout);
    end

    // Doubling boundary lanes and latency
    @(posedge clk); #1;
    ia.ivalid = 1; ia.kb_vin = {32'hFFFFFFFF, 32'h7FFFFFFF, 32'd2, 32'd1};
    @(posedge clk); #1;
    ia.ivalid = 0;
    checks++;
    assert (ia.ovalid === 1'b0) else begin
      errs++; $error("FAIL lat_early observed=%b expected=0", ia.ovalid);
    end
    @(posedge clk); #1;
    checks++;
    assert (ia.ovalid === 1'b1 && ia.kb_vout === {32'hFFFFFFFE, 32'hFFFFFFFE, 32'd4, 32'd2}) else begin
      errs++; $error("FAIL double_vec observed=%b/%h expected=1/fffffffefffffffe0000000400000002", ia.ovalid, ia.kb_vout);
    end

    // Squaring boundary lanes and latency
    @(posedge clk); #1;
    ia.ivalid = 1; ia.kb_vin = {32'd0, 32'h0000FFFF, 32'h00010000, 32'd3};
    @(posedge clk); #1;
    ia.ivalid = 0;
    @(posedge clk); #1;
    checks++;
    assert (ib.ovalid === 1'b1 && ib.olast === 1'b1 && ib.kb_vout === {32'd0, 32'hFFFE0001, 32'd0, 32'd9}) else begin
      errs++; $error("FAIL square_vec observed=%b/%b/%h expected=1/1/00000000fffe00010000000000000009", ib.ovalid, ib.olast, ib.kb_vout);
    end
    drain("drain_directed");

    // Eight-beat stream with a three-cycle downstream stall
    do_reset();
    stream(8, 1);
    drain("drain_stall");

    // Work-group of four over nine beats with random backpressure
    do_reset();
    stream(9, 2);
    drain("drain_random");
    checks++;
    assert (lasts_a == 2 && cnt_a == 1) else begin
      errs++; $error("FAIL olast_count observed=%0d/%0d expected=2/1", lasts_a, cnt_a);
    end

    // Reset with two beats in flight
    do_reset();
    @(posedge clk); #1;
    ia.ivalid = 1; ia.kb_vin = rnd();
    @(posedge clk); #1;
    ia.kb_vin = rnd();
    @(posedge clk); #1;
    rst = 1; ia.ivalid = 0;
    @(posedge clk); #1;
    rst = 0;
    qa.delete(); qb.delete(); cnt_a = 0; lasts_a = 0; stall_a = 0; stall_b = 0;
    check_idle("midrst_idle");
    repeat (3) @(posedge clk);
    #1;
    check_idle("midrst_no_emit");
    stream(4, 0);
    drain("drain_midrst");
    checks++;
    assert (lasts_a == 1 && cnt_a == 0) else begin
      errs++; $error("FAIL midrst_olast observed=%0d/%0d expected=1/0", lasts_a, cnt_a);
    end

    // Offered beats while blocked must never surface
    do_reset();
    ia.oready = 0;
    repeat (2) begin
      @(posedge clk); #1;
      ia.ivalid = 1; ia.kb_vin = rnd();
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      ia.kb_vin = rnd();
      checks++;
      assert (ia.iready === 1'b0 && ib.iready === 1'b0) else begin
        errs++; $error("FAIL blocked_iready observed=%b/%b expected=0/0", ia.iready, ib.iready);
      end
    end
    @(posedge clk); #1;
    ia.ivalid = 0;
    checks++;
    assert (qa.size() == 2 && qb.size() == 2) else begin
      errs++; $error("FAIL blocked_accepts observed=%0d/%0d expected=2/2", qa.size(), qb.size());
    end
    drain("drain_blocked");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/kerneltop_kernel_b_vec.md
KERNELTOP_KERNEL_B_VEC -- requirements
Module: kerneltop_kernel_b_vec

Interface
REQ-001 Parameter: STREAMW, default 32, width of one lane element in bits.
REQ-002 Parameter: NLANES, default 4, number of parallel lanes (1..16).
REQ-003 Parameter: PIPE_DEPTH, default 2, number of register stages from input to output (1..4).
REQ-004 Parameter: OPMODE, default 0; 0 selects lane doubling (x+x), 1 selects lane squaring (x*x).
REQ-005 Parameter: NITEMS, default 1024, number of output beats per work-group (>=1).
REQ-006 The block SHALL use one clock; reset is synchronous and active-high.
REQ-007 Port: clk  in  1  rising-edge clock.
REQ-008 Port: rst  in  1  synchronous active-high reset.
REQ-009 Port: ivalid  in  1  upstream beat valid.
REQ-010 Port: iready  out  1  block can accept a beat this cycle.
REQ-011 Port: kb_vin  in  NLANES*STREAMW  input vector; lane i occupies bits [i*STREAMW +: STREAMW].
REQ-012 Port: ovalid  out  1  output beat valid.
REQ-013 Port: oready  in  1  downstream can accept a beat.
REQ-014 Port: kb_vout  out  NLANES*STREAMW  result vector, same lane packing as kb_vin.
REQ-015 Port: olast  out  1  qualifies the final beat of a work-group; meaningful only while ovalid=1.

Function
REQ-016 Per lane, OPMODE=0 SHALL compute (x+x) mod 2^STREAMW; OPMODE=1 SHALL compute the low STREAMW bits of the unsigned product x*x.
REQ-017 All lanes SHALL share one valid bit per stage; lanes never desynchronise.
REQ-018 An input beat is accepted iff ivalid=1 and iready=1 on a rising edge; it is dropped otherwise.
REQ-019 Pipeline advance enable: en = ~v[PIPE_DEPTH-1] | oready; iready SHALL equal en (combinational from oready).
REQ-020 When en=1, every stage SHALL load from its predecessor; stage 0 loads the input with valid = ivalid.
REQ-021 When en=0, all stage data and valid bits SHALL hold.
REQ-022 ovalid SHALL equal v[PIPE_DEPTH-1]; kb_vout SHALL be the last stage data.
REQ-023 While ovalid=1 and oready=0, kb_vout and olast SHALL remain stable until the handshake completes.
REQ-024 Latency: an accepted beat SHALL appear on ovalid exactly PIPE_DEPTH cycles after acceptance while oready stays high.
REQ-025 Throughput: one beat per cycle sustained when ivalid=oready=1.
REQ-026 Bubbles (v=0 stages) SHALL be squeezed out only by global advance; no per-stage compaction is required.
REQ-027 An output beat counter, width clog2(NITEMS) (min 1), SHALL increment on each ovalid&oready handshake.
REQ-028 olast SHALL be 1 when ovalid=1 and the counter equals NITEMS-1.
REQ-029 On a handshake with counter=NITEMS-1, the counter SHALL wrap to 0.
REQ-030 NITEMS=1: olast SHALL be 1 on every valid beat; the counter stays 0.
REQ-031 Squaring SHALL be fully contained within the PIPE_DEPTH stages; no additional latency for either OPMODE.

Reset
REQ-032 While rst=1 at a clock edge: all stage valid bits, the beat counter, and stage data SHALL clear to 0.
REQ-033 After reset: ovalid=0, olast=0, kb_vout=0; iready=1 (pipeline empty).
REQ-034 Reset mid-operation SHALL discard all in-flight beats and restart the work-group count at 0; no partial beat is emitted.
REQ-035 rst SHALL take precedence over any simultaneous handshake.

Verification
REQ-036 Default params, OPMODE=0, oready=1; drive lanes {1,2,0x7FFFFFFF,0xFFFFFFFF} -> 2 cycles later ovalid=1, kb_vout lanes {2,4,0xFFFFFFFE,0xFFFFFFFE}.
REQ-037 OPMODE=1, lanes {3,0x10000,0xFFFF,0} -> {9,0,0xFFFE0001,0} after PIPE_DEPTH cycles.
REQ-038 Stream 8 beats continuously; hold oready=0 for cycles 4-6 -> iready=0 during the stall, kb_vout stable, all 8 results in order with no loss or duplicates.
REQ-039 NITEMS=4, stream 9 beats with random oready -> olast=1 on beats 4 and 8 only; counter=1 after beat 9.
REQ-040 Assert rst for one cycle with 2 beats in flight -> next cycle ovalid=0, olast=0, iready=1; the next accepted beat appears with olast only after NITEMS further beats.
REQ-041 ivalid=1 with iready=0 for 3 cycles, changing kb_vin each cycle -> none of those values appear on kb_vout.
